timer_ctrl: RTL and testbench

Control FSM for the kitchen-timer counter chain: seconds-units mod-10, seconds-tens mod-6 and minutes mod-10 down counters.
- Collects keypad digits into a preset register.
- Drives the chain's shared cnt_loadn, cnt_clearn and cnt_en strobes from a 1 s prescaler.
- Handles start/stop/clear buttons and the door interlock, and detects expiry from the chain's all-zero flag.
- Sits between the user-input debouncers and the counter chain/display.

---
 rtl/timer_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: control FSM for the kitchen-timer down-counter chain.
// The chain is seconds-units mod 10, seconds-tens mod 6 and minutes mod 10.
//
// Ports:
//   clk, clearn        clock (rising edge), synchronous active-low reset
//   start/stop/clr     one-cycle request pulses from the debouncers
//   door_closed        door interlock, 1 = closed
//   key_valid/digit    keypad BCD digit entry
//   cnt_zero           all counter stages at zero
//   preset_*           preset digits loaded into the chain
//   cnt_loadn          chain load strobe, active low
//   cnt_clearn         chain clear strobe, active low
//   cnt_en             chain decrement pulse, one per second tick
//   mag_on, done       heater enable, expiry flag
//   state              IDLE=0 RUN=1 PAUSE=2 DONE=3
//   beep               expiry beep
//
// Optional build macro TIMER_CTRL_DONE_BEEP_EN: beep is driven for
// BEEP_CYCLES cycles on entry to DONE. Without the macro, beep is tied to 0.
module timer_ctrl #(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned BEEP_CYCLES = 50
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       cnt_zero,
  output logic [3:0] preset_min,
  output logic [2:0] preset_sec_tens,
  output logic [3:0] preset_sec_units,
  output logic       cnt_loadn,
  output logic       cnt_clearn,
  output logic       cnt_en,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state,
  output logic       beep
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 4) begin : g_bad_tick_div
    $error("timer_ctrl: TICK_DIV must be >= 4");
  end
  if (BEEP_CYCLES < 1) begin : g_bad_beep_cycles
    $error("timer_ctrl: BEEP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    min_q, min_d;
  logic [2:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          loadn_q, loadn_d;
  logic          clrn_q, clrn_d;
  logic          en_q, en_d;
  logic          mag_q, mag_d;
  logic          done_q, done_d;

  logic preset_nz;
  assign preset_nz = (min_q != '0) || (tens_q != '0) || (units_q != '0);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    units_d = units_q;
    presc_d = presc_q;
    loadn_d = 1'b1;
    clrn_d  = 1'b1;
    en_d    = 1'b0;

    if (clr) begin
      state_d = IDLE;
      min_d   = '0;
      tens_d  = '0;
      units_d = '0;
      presc_d = '0;
      clrn_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // stop outranks start/key and is a no-op here, so it consumes the cycle
          if (stop) begin
            state_d = IDLE;
          end else if (start && door_closed && preset_nz) begin
            loadn_d = 1'b0;
            presc_d = '0;
            state_d = RUN;
          end else if (key_valid && (key_digit <= 4'd9)) begin
            min_d   = {1'b0, tens_q};
            tens_d  = (units_q > 4'd5) ? 3'd5 : units_q[2:0];
            units_d = key_digit;
          end
        end
        RUN: begin
          if (stop || !door_closed) begin
            state_d = PAUSE;
          end else if (cnt_zero && !en_q && loadn_q) begin
            // Gating on the registered strobes waits out the chain's update
            // from the last load/decrement before trusting cnt_zero.
            state_d = DONE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            en_d    = !cnt_zero;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (stop) begin
            state_d = IDLE;
            clrn_d  = 1'b0;
          end else if (start && door_closed) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (start || stop || key_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    mag_d  = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!clearn) begin
      state_q <= IDLE;
      min_q   <= '0;
      tens_q  <= '0;
      units_q <= '0;
      presc_q <= '0;
      loadn_q <= 1'b1;
      clrn_q  <= 1'b0;
      en_q    <= 1'b0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      presc_q <= presc_d;
      loadn_q <= loadn_d;
      clrn_q  <= clrn_d;
      en_q    <= en_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

`ifdef TIMER_CTRL_DONE_BEEP_EN
  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;

  always_comb begin
    beep_cnt_d = '0;
    beep_d     = 1'b0;
    if (state_d == DONE) begin
      if (state_q != DONE) begin
        beep_d     = 1'b1;
        beep_cnt_d = BW'(BEEP_CYCLES - 1);
      end else if (beep_cnt_q != '0) begin
        beep_d     = 1'b1;
        beep_cnt_d = beep_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clearn) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

  assign preset_min       = min_q;
  assign preset_sec_tens  = tens_q;
  assign preset_sec_units = units_q;
  assign cnt_loadn        = loadn_q;
  assign cnt_clearn       = clrn_q;
  assign cnt_en           = en_q;
  assign mag_on           = mag_q;
  assign done             = done_q;
  assign state            = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

`ifdef TIMER_CTRL_DONE_BEEP_EN
  localparam logic BEEP_ON = 1'b1;
`else
  localparam logic BEEP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clr = 1'b0;
  logic       door_closed = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       cnt_zero;
  logic [3:0] preset_min;
  logic [2:0] preset_sec_tens;
  logic [3:0] preset_sec_units;
  logic       cnt_loadn, cnt_clearn, cnt_en, mag_on, done, beep;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.TICK_DIV(4), .BEEP_CYCLES(5)) dut (
    .clk(clk), .clearn(clearn), .start(start), .stop(stop), .clr(clr),
    .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
    .cnt_zero(cnt_zero), .preset_min(preset_min),
    .preset_sec_tens(preset_sec_tens), .preset_sec_units(preset_sec_units),
    .cnt_loadn(cnt_loadn), .cnt_clearn(cnt_clearn), .cnt_en(cnt_en),
    .mag_on(mag_on), .done(done), .state(state), .beep(beep)
  );

  always #5 clk = ~clk;

  // Behavioural model of the counter chain fed by the DUT strobes.
  logic [3:0] m_min = 4'd0;
  logic [2:0] m_tens = 3'd0;
  logic [3:0] m_units = 4'd0;
  assign cnt_zero = (m_min == 4'd0) && (m_tens == 3'd0) && (m_units == 4'd0);

  always @(posedge clk) begin
    if (!cnt_clearn) begin
      m_min <= 4'd0; m_tens <= 3'd0; m_units <= 4'd0;
    end else if (!cnt_loadn) begin
      m_min <= preset_min; m_tens <= preset_sec_tens; m_units <= preset_sec_units;
    end else if (cnt_en) begin
      if (m_units != 4'd0) m_units <= m_units - 4'd1;
      else begin
        m_units <= 4'd9;
        if (m_tens != 3'd0) m_tens <= m_tens - 3'd1;
        else begin
          m_tens <= 3'd5;
          m_min  <= (m_min == 4'd0) ? 4'd9 : m_min - 4'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic pulse_stop();  stop  = 1'b1; step(); stop  = 1'b0; endtask
  task automatic pulse_clr();   clr   = 1'b1; step(); clr   = 1'b0; endtask

  task automatic test_reset();
    clearn = 1'b0;
    step(); step();
    checks++;
    if ({state, preset_min, preset_sec_tens, preset_sec_units} !== 13'd0) begin
      errors++; $display("FAIL reset_state_presets got %h exp 0", {state, preset_min, preset_sec_tens, preset_sec_units});
    end
    checks++;
    if ({cnt_loadn, cnt_clearn, cnt_en, mag_on, done, beep} !== 6'b100000) begin
      errors++; $display("FAIL reset_outputs got %b exp 100000", {cnt_loadn, cnt_clearn, cnt_en, mag_on, done, beep});
    end
    clearn = 1'b1;
    step();
    checks++;
    if (cnt_clearn !== 1'b1) begin errors++; $display("FAIL reset_release_clearn got %b exp 1", cnt_clearn); end
  endtask

  task automatic test_keys_start();
    int pulses = 0;
    int first = 0;
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    checks++;
    if ({preset_min, preset_sec_tens, preset_sec_units} !== {4'd1, 3'd3, 4'd0}) begin
      errors++; $display("FAIL keys_130 got %h %h %h exp 1 3 0", preset_min, preset_sec_tens, preset_sec_units);
    end
    door_closed = 1'b1;
    pulse_start();
    checks++;
    if ({cnt_loadn, state, mag_on} !== {1'b0, 2'd1, 1'b1}) begin
      errors++; $display("FAIL start_load got loadn=%b state=%0d mag=%b exp 0 1 1", cnt_loadn, state, mag_on);
    end
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) begin
        checks++;
        if (cnt_loadn !== 1'b1) begin errors++; $display("FAIL load_one_cycle got %b exp 1", cnt_loadn); end
      end
      if (cnt_en === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    checks++;
    if (pulses != 4 || first != 4) begin
      errors++; $display("FAIL tick_rate got pulses=%0d first=%0d exp 4 4", pulses, first);
    end
    pulse_clr();
    step();
  endtask

  task automatic test_saturation();
    press_key(4'd7); press_key(4'd9);
    checks++;
    if ({preset_min, preset_sec_tens, preset_sec_units} !== {4'd0, 3'd5, 4'd9}) begin
      errors++; $display("FAIL sat_79 got %h %h %h exp 0 5 9", preset_min, preset_sec_tens, preset_sec_units);
    end
    press_key(4'hA);
    checks++;
    if ({preset_min, preset_sec_tens, preset_sec_units} !== {4'd0, 3'd5, 4'd9}) begin
      errors++; $display("FAIL key_invalid got %h %h %h exp 0 5 9", preset_min, preset_sec_tens, preset_sec_units);
    end
    press_key(4'd2);
    checks++;
    if ({preset_min, preset_sec_tens, preset_sec_units} !== {4'd5, 3'd5, 4'd2}) begin
      errors++; $display("FAIL shift_min got %h %h %h exp 5 5 2", preset_min, preset_sec_tens, preset_sec_units);
    end
    pulse_clr();
    step();
  endtask

  task automatic test_expiry();
    int pulses = 0;
    int last = 0;
    int donec = 0;
    press_key(4'd0); press_key(4'd2);
    pulse_start();
    for (int c = 1; c <= 40 && donec == 0; c++) begin
      step();
      if (cnt_en === 1'b1) begin pulses++; last = c; end
      if (done === 1'b1) donec = c;
    end
    checks++;
    if (donec == 0) begin
      errors++; $display("FAIL expiry_timeout got done=0 exp done within 40 cycles");
    end else begin
      checks++;
      if (pulses != 2 || donec != last + 2) begin
        errors++; $display("FAIL expiry_timing got pulses=%0d last=%0d done=%0d exp 2 pulses done=last+2", pulses, last, donec);
      end
      checks++;
      if ({state, mag_on, beep} !== {2'd3, 1'b0, BEEP_ON}) begin
        errors++; $display("FAIL expiry_outputs got state=%0d mag=%b beep=%b exp 3 0 %b", state, mag_on, beep, BEEP_ON);
      end
      step();
      checks++;
      if ({state, cnt_en, beep} !== {2'd3, 1'b0, BEEP_ON}) begin
        errors++; $display("FAIL beep_cycle2 got state=%0d en=%b beep=%b exp 3 0 %b", state, cnt_en, beep, BEEP_ON);
      end
      pulse_start();
      checks++;
      if ({state, done, beep, cnt_loadn} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL done_exit got state=%0d done=%b beep=%b loadn=%b exp 0 0 0 1", state, done, beep, cnt_loadn);
      end
      checks++;
      if ({preset_min, preset_sec_tens, preset_sec_units} !== {4'd0, 3'd0, 4'd2}) begin
        errors++; $display("FAIL done_presets_kept got %h %h %h exp 0 0 2", preset_min, preset_sec_tens, preset_sec_units);
      end
    end
  endtask

  task automatic test_beep_length();
    int beeps = 0;
    int pulses = 0;
    int seen = 0;
    pulse_clr();
    press_key(4'd1);
    pulse_start();
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      step();
      if (cnt_en === 1'b1) pulses++;
      if (done === 1'b1) seen = c;
    end
    checks++;
    if (seen != 6 || pulses != 1) begin
      errors++; $display("FAIL expiry_one_sec got done_cycle=%0d pulses=%0d exp 6 1", seen, pulses);
    end
    if (beep === 1'b1) beeps++;
    for (int c = 0; c < 8; c++) begin
      step();
      if (beep === 1'b1) beeps++;
      if (cnt_en === 1'b1) pulses++;
    end
    checks++;
    if (beeps != (BEEP_ON ? 5 : 0) || done !== 1'b1 || pulses != 1) begin
      errors++; $display("FAIL beep_length got beeps=%0d done=%b pulses=%0d exp %0d 1 1", beeps, done, pulses, BEEP_ON ? 5 : 0);
    end
    press_key(4'd7);
    checks++;
    if ({state, preset_min, preset_sec_tens, preset_sec_units} !== {2'd0, 4'd0, 3'd0, 4'd1}) begin
      errors++; $display("FAIL done_key_exit got state=%0d presets %h %h %h exp 0 0 0 1", state, preset_min, preset_sec_tens, preset_sec_units);
    end
  endtask

  task automatic test_door_pause();
    int silent = 1;
    int wait_c = 0;
    pulse_clr();
    press_key(4'd5); press_key(4'd0); press_key(4'd0);
    pulse_start();
    repeat (6) step();
    door_closed = 1'b0;
    step();
    checks++;
    if ({state, mag_on} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL door_pause got state=%0d mag=%b exp 2 0", state, mag_on);
    end
    for (int c = 0; c < 9; c++) begin
      step();
      if (cnt_en !== 1'b0 || state !== 2'd2) silent = 0;
    end
    pulse_start();
    checks++;
    if (silent != 1 || state !== 2'd2) begin
      errors++; $display("FAIL door_open_hold got silent=%0d state=%0d exp 1 2", silent, state);
    end
    door_closed = 1'b1;
    pulse_start();
    checks++;
    if ({state, mag_on} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL resume got state=%0d mag=%b exp 1 1", state, mag_on);
    end
    for (int c = 1; c <= 8 && wait_c == 0; c++) begin
      step();
      if (cnt_en === 1'b1) wait_c = c;
    end
    checks++;
    if (wait_c != 2) begin errors++; $display("FAIL resume_prescaler got %0d exp 2", wait_c); end
  endtask

  task automatic test_clr_priority();
    clr = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; start = 1'b0;
    checks++;
    if ({state, preset_min, preset_sec_tens, preset_sec_units, cnt_clearn, mag_on} !== 15'd0) begin
      errors++; $display("FAIL clr_wins got state=%0d presets %h %h %h clearn=%b mag=%b exp all 0", state, preset_min, preset_sec_tens, preset_sec_units, cnt_clearn, mag_on);
    end
    step();
    checks++;
    if (cnt_clearn !== 1'b1) begin errors++; $display("FAIL clr_pulse_len got %b exp 1", cnt_clearn); end
    press_key(4'd1); press_key(4'd0); press_key(4'd0);
    pulse_start();
    step(); step();
    pulse_stop();
    checks++;
    if ({state, cnt_clearn, mag_on} !== {2'd2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL stop_pause got state=%0d clearn=%b mag=%b exp 2 1 0", state, cnt_clearn, mag_on);
    end
    pulse_stop();
    checks++;
    if ({state, cnt_clearn, preset_min, preset_sec_tens, preset_sec_units} !== {2'd0, 1'b0, 4'd1, 3'd0, 4'd0}) begin
      errors++; $display("FAIL stop_idle got state=%0d clearn=%b presets %h %h %h exp 0 0 1 0 0", state, cnt_clearn, preset_min, preset_sec_tens, preset_sec_units);
    end
    step();
    checks++;
    if (cnt_clearn !== 1'b1 || cnt_zero !== 1'b1) begin
      errors++; $display("FAIL stop_chain_cleared got clearn=%b zero=%b exp 1 1", cnt_clearn, cnt_zero);
    end
  endtask

  task automatic test_zero_start();
    pulse_clr();
    pulse_start();
    checks++;
    if ({state, cnt_loadn, mag_on} !== {2'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL zero_start got state=%0d loadn=%b mag=%b exp 0 1 0", state, cnt_loadn, mag_on);
    end
    press_key(4'd5);
    door_closed = 1'b0;
    pulse_start();
    door_closed = 1'b1;
    checks++;
    if ({state, cnt_loadn} !== {2'd0, 1'b1}) begin
      errors++; $display("FAIL door_open_start got state=%0d loadn=%b exp 0 1", state, cnt_loadn);
    end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    step(); step();
    clearn = 1'b0;
    step();
    checks++;
    if ({state, preset_sec_units, cnt_clearn, mag_on, cnt_loadn} !== {2'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_midrun got state=%0d units=%h clearn=%b mag=%b loadn=%b exp 0 0 0 0 1", state, preset_sec_units, cnt_clearn, mag_on, cnt_loadn);
    end
    clearn = 1'b1;
    step();
    checks++;
    if (cnt_clearn !== 1'b1 || cnt_zero !== 1'b1) begin
      errors++; $display("FAIL reset_midrun_release got clearn=%b zero=%b exp 1 1", cnt_clearn, cnt_zero);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_keys_start();
    test_saturation();
    test_expiry();
    test_beep_length();
    test_door_pause();
    test_clr_priority();
    test_zero_start();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
